// File: rtl/wb_gpio_irq_if.sv
// Wishbone classic slave bus bundle for wb_gpio_irq.
// Signal names are seen from the peripheral side (_i into the slave, _o out of it).
//   master modport : drives address/data/we/cyc/stb, receives ack/read data
//   slave  modport : receives address/data/we/cyc/stb, drives ack/read data
interface wb_gpio_irq_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO peripheral with per-pin interrupt sources.
//   clk      : single clock
//   rst      : asynchronous reset, active low
//   wb       : Wishbone slave bundle (wb_gpio_irq_if.slave)
//   gpio_io  : pads; bit i driven with DATA_OUT[i] when DIR[i]=1, else high-Z
//   irq      : registered level interrupt, |(IRQ_STATUS & IRQ_EN)
// Register map (word offset adr[4:2]):
//   0 DATA_IN (RO)  1 DATA_OUT  2 DIR  3 IRQ_EN  4 IRQ_MODE  5 IRQ_POL
//   6 IRQ_STATUS (W1C)  7 OUT_TOGGLE (WO, reads 0)

// Per-pin slice: input synchroniser, previous-value flop and sticky status.
//   pad_i            : raw pad value
//   en_i/mode_i/...  : this pin's control bits
//   clr_i            : W1C strobe for this status bit
//   sync_o           : synchronised pad value
//   status_o         : sticky interrupt status
module wb_gpio_irq_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  input  logic en_i,
  input  logic mode_i,
  input  logic pol_i,
  input  logic dir_i,
  input  logic clr_i,
  output logic sync_o,
  output logic status_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, status_q, status_d, hit;

  assign sync_o   = sync_q[SYNC_STAGES-1];
  assign status_o = status_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    // Edge mode additionally needs a change against the previous sample.
    hit = en_i & ~dir_i & (sync_o == pol_i) & (~mode_i | (sync_o != prev_q));
    // A new hit in the same cycle as a W1C keeps the bit set.
    status_d = (status_q & ~clr_i) | hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= sync_o;
      status_q <= status_d;
    end
  end
endmodule

module wb_gpio_irq #(
  parameter int                    GPIO_WIDTH  = 8,
  parameter logic [GPIO_WIDTH-1:0] DIR_RESET   = '0,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET   = '0,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_gpio_irq_if.slave          wb,
  inout  wire  [GPIO_WIDTH-1:0] gpio_io,
  output logic                  irq
);
  localparam int W = GPIO_WIDTH;

  typedef enum logic {S_IDLE, S_ACK} state_e;

  state_e      state_q;
  logic        ack_q;
  logic [31:0] dat_q, rdata;

  logic [W-1:0] out_q, dir_q, en_q, mode_q, pol_q;
  logic [W-1:0] out_d, dir_d, en_d, mode_d, pol_d;
  logic [W-1:0] sync, status, clr, wdat;
  logic         irq_q;

  logic [2:0] sel;
  logic       req, wr;
  logic       unused_bits;

  assign sel  = wb.wb_adr_i[4:2];
  assign req  = wb.wb_cyc_i & wb.wb_stb_i;
  // Requests are only taken in IDLE, so the ACK cycle never re-accepts.
  assign wr   = req & wb.wb_we_i & (state_q == S_IDLE);
  assign wdat = wb.wb_dat_i[W-1:0];
  assign clr  = (wr && sel == 3'd6) ? wdat : '0;

  assign wb.wb_ack_o = ack_q & req;
  assign wb.wb_dat_o = dat_q;
  assign irq         = irq_q;

  assign unused_bits = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i};

  function automatic logic [31:0] zext(input logic [W-1:0] v);
    zext = '0;
    zext[W-1:0] = v;
  endfunction

  always_comb begin
    rdata = '0;
    case (sel)
      3'd0:    rdata = zext(sync);
      3'd1:    rdata = zext(out_q);
      3'd2:    rdata = zext(dir_q);
      3'd3:    rdata = zext(en_q);
      3'd4:    rdata = zext(mode_q);
      3'd5:    rdata = zext(pol_q);
      3'd6:    rdata = zext(status);
      default: rdata = '0;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    mode_d = mode_q;
    pol_d  = pol_q;
    if (wr) begin
      case (sel)
        3'd1:    out_d  = wdat;
        3'd2:    dir_d  = wdat;
        3'd3:    en_d   = wdat;
        3'd4:    mode_d = wdat;
        3'd5:    pol_d  = wdat;
        3'd7:    out_d  = out_q ^ wdat;
        default: ;
      endcase
    end
  end

  // Bus FSM: one access, one ack cycle, back to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          state_q <= S_ACK;
          ack_q   <= 1'b1;
          dat_q   <= wb.wb_we_i ? 32'h0 : rdata;
        end
        S_ACK: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= OUT_RESET;
      dir_q  <= DIR_RESET;
      en_q   <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      pol_q  <= pol_d;
      irq_q  <= |(status & en_q);
    end
  end

  wb_gpio_irq_bit #(.SYNC_STAGES(SYNC_STAGES)) u_bit [W-1:0] (
    .clk      (clk),
    .rst      (rst),
    .pad_i    (gpio_io),
    .en_i     (en_q),
    .mode_i   (mode_q),
    .pol_i    (pol_q),
    .dir_i    (dir_q),
    .clr_i    (clr),
    .sync_o   (sync),
    .status_o (status)
  );

  for (genvar i = 0; i < W; i++) begin : g_pad
    assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
  end
endmodule

// File: tb/tb_wb_gpio_irq.sv
// Scoreboard bench for wb_gpio_irq: a cycle-level reference model predicts
// read data (queued on acceptance), irq and driven pads; a monitor compares.
module tb_wb_gpio_irq;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam logic [W-1:0] DIR_RST = 8'h0F;
  localparam logic [W-1:0] OUT_RST = 8'h05;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_gpio_irq_if bus ();
  wire  [W-1:0] gpio_io;
  logic         irq;
  logic [W-1:0] tb_drv = '0;

  int nchk = 0;
  int nerr = 0;

  // Reference model state
  logic [W-1:0] m_out = OUT_RST, m_dir = DIR_RST;
  logic [W-1:0] m_en = '0, m_mode = '0, m_pol = '0, m_st = '0, m_prev = '0;
  logic [W-1:0] m_hist [SS];
  logic         m_irq = 1'b0, m_busy = 1'b0;
  logic [31:0]  exp_q [$];

  wb_gpio_irq #(
    .GPIO_WIDTH (W), .DIR_RESET (DIR_RST), .OUT_RESET (OUT_RST), .SYNC_STAGES (SS)
  ) dut (
    .clk (clk), .rst (rst), .wb (bus), .gpio_io (gpio_io), .irq (irq)
  );

  // Bench drives only the pins the peripheral treats as inputs.
  for (genvar i = 0; i < W; i++) begin : g_pad
    assign gpio_io[i] = m_dir[i] ? 1'bz : tb_drv[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a, input logic [W-1:0] s);
    logic [W-1:0] v;
    case (a)
      3'd0: v = s;
      3'd1: v = m_out;
      3'd2: v = m_dir;
      3'd3: v = m_en;
      3'd4: v = m_mode;
      3'd5: v = m_pol;
      3'd6: v = m_st;
      default: v = '0;
    endcase
    return {24'h0, v};
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [W-1:0] pad, s, hit, clr, wd;
    logic nirq;
    if (!rst) begin
      m_out = OUT_RST; m_dir = DIR_RST;
      m_en = '0; m_mode = '0; m_pol = '0; m_st = '0; m_prev = '0;
      m_irq = 1'b0; m_busy = 1'b0;
      for (int k = 0; k < SS; k++) m_hist[k] = '0;
      exp_q.delete();
    end else begin
      pad = (m_dir & m_out) | (~m_dir & tb_drv);
      s   = m_hist[SS-1];
      for (int i = 0; i < W; i++) begin
        hit[i] = 1'b0;
        if (m_en[i] && !m_dir[i] && s[i] == m_pol[i])
          hit[i] = m_mode[i] ? (s[i] != m_prev[i]) : 1'b1;
      end
      nirq = |(m_st & m_en);
      clr  = '0;
      if (bus.wb_cyc_i && bus.wb_stb_i && !m_busy) begin
        m_busy = 1'b1;
        if (bus.wb_we_i) begin
          exp_q.push_back(32'h0);
          wd = bus.wb_dat_i[W-1:0];
          case (bus.wb_adr_i[4:2])
            3'd1: m_out  = wd;
            3'd2: m_dir  = wd;
            3'd3: m_en   = wd;
            3'd4: m_mode = wd;
            3'd5: m_pol  = wd;
            3'd6: clr    = wd;
            3'd7: m_out  = m_out ^ wd;
            default: ;
          endcase
        end else begin
          exp_q.push_back(m_read(bus.wb_adr_i[4:2], s));
        end
      end else begin
        m_busy = 1'b0;
      end
      m_st   = (m_st & ~clr) | hit;
      m_prev = s;
      m_irq  = nirq;
      for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = pad;
    end
  end

  // Monitor: read data on every ack, irq and driven pads every cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.wb_ack_o) begin
        if (exp_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_ack: got ack with data %h, expected no ack", bus.wb_dat_o);
        end else begin
          chk("rdata", bus.wb_dat_o, exp_q.pop_front());
        end
      end
      chk("irq", {31'h0, irq}, {31'h0, m_irq});
      chk("pads", {24'h0, gpio_io & m_dir}, {24'h0, m_out & m_dir});
    end
  end

  task automatic bus_op(input logic we, input logic [2:0] a, input logic [31:0] d);
    int n;
    logic [31:0] hi;
    n  = 0;
    hi = $urandom;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = {hi[26:0], a, 2'b00}; bus.wb_dat_i = d;
    do begin @(negedge clk); n++; end while (!bus.wb_ack_o && n < 8);
    chk("ack_latency", n, 1);
    @(negedge clk);
    chk("ack_width", {31'h0, bus.wb_ack_o}, 32'h0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state
    chk("irq_rst", {31'h0, irq}, 32'h0);
    chk("ack_rst", {31'h0, bus.wb_ack_o}, 32'h0);
    chk("pads_rst", {28'h0, gpio_io[3:0]}, 32'h5);
    bus_op(1'b0, 3'd2, 32'h0);
    chk("dir_rst", bus.wb_dat_o, 32'h0F);
    bus_op(1'b0, 3'd1, 32'h0);
    chk("out_rst", bus.wb_dat_o, 32'h05);

    // Output path and toggle
    bus_op(1'b1, 3'd1, 32'hA5);
    bus_op(1'b1, 3'd2, 32'hFF);
    bus_op(1'b1, 3'd7, 32'h0F);
    chk("pads_toggle", {24'h0, gpio_io}, 32'hAA);
    bus_op(1'b0, 3'd7, 32'h0);
    chk("toggle_reads0", bus.wb_dat_o, 32'h0);

    // Rising edge on pin 0
    bus_op(1'b1, 3'd2, 32'h00);
    bus_op(1'b1, 3'd4, 32'h01);
    bus_op(1'b1, 3'd5, 32'h01);
    bus_op(1'b1, 3'd3, 32'h01);
    repeat (3) @(negedge clk);
    tb_drv[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("edge_irq_k2", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("edge_irq_k3", {31'h0, irq}, 32'h1);
    bus_op(1'b1, 3'd6, 32'h01);
    chk("w1c_irq_low", {31'h0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    bus_op(1'b0, 3'd6, 32'h0);
    chk("edge_no_reset", bus.wb_dat_o, 32'h0);

    // Level active-low on pin 3, held
    bus_op(1'b1, 3'd3, 32'h00);
    bus_op(1'b1, 3'd4, 32'h00);
    bus_op(1'b1, 3'd5, 32'h00);
    bus_op(1'b1, 3'd3, 32'h08);
    repeat (4) @(negedge clk);
    bus_op(1'b1, 3'd6, 32'h08);
    chk("level_irq_held", {31'h0, irq}, 32'h1);
    bus_op(1'b0, 3'd6, 32'h0);
    chk("level_reset", bus.wb_dat_o & 32'h08, 32'h08);

    // Falling edge on pin 5 coinciding with W1C
    bus_op(1'b1, 3'd3, 32'h00);
    bus_op(1'b1, 3'd6, 32'hFF);
    bus_op(1'b1, 3'd4, 32'h20);
    @(negedge clk);
    tb_drv[5] = 1'b1;
    repeat (4) @(negedge clk);
    bus_op(1'b1, 3'd3, 32'h20);
    @(negedge clk);
    tb_drv[5] = 1'b0;
    @(negedge clk);
    bus_op(1'b1, 3'd6, 32'h20);
    chk("set_wins_irq", {31'h0, irq}, 32'h1);
    bus_op(1'b0, 3'd6, 32'h0);
    chk("set_wins_status", bus.wb_dat_o, 32'h20);

    // Random traffic
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        tb_drv = W'($urandom);
      end
      bus_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
    end

    // Reset in the middle of an access
    bus_op(1'b1, 3'd2, 32'hF0);
    bus_op(1'b1, 3'd3, 32'hFF);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h8;
    @(posedge clk);
    #1;
    chk("ack_pre_reset", {31'h0, bus.wb_ack_o}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("ack_in_reset", {31'h0, bus.wb_ack_o}, 32'h0);
    chk("irq_in_reset", {31'h0, irq}, 32'h0);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_op(1'b0, 3'd2, 32'h0);
    chk("dir_after_reset", bus.wb_dat_o, 32'h0F);
    bus_op(1'b0, 3'd1, 32'h0);
    chk("out_after_reset", bus.wb_dat_o, 32'h05);
    bus_op(1'b0, 3'd3, 32'h0);
    chk("en_after_reset", bus.wb_dat_o, 32'h0);
    bus_op(1'b0, 3'd6, 32'h0);
    chk("status_after_reset", bus.wb_dat_o, 32'h0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
